// File: rtl/wb_req_guard_pkg.sv
// -----------------------------------------------------------------------------
// wb_req_guard_pkg
// Shared definitions for the register-to-Wishbone request guard:
//   - state_e  : FSM state encoding (IDLE, BUS, RELEASE)
//   - TMR_W    : width of the bus-phase timeout counter / limit
//   - ERR_DATA : all-ones read data returned on error or timeout; users slice
//                the low DW bits
// -----------------------------------------------------------------------------
package wb_req_guard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUS     = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam int TMR_W = 16;

  localparam int MAX_DW = 1024;
  localparam logic [MAX_DW-1:0] ERR_DATA = '1;

endpackage

// File: rtl/wb_req_guard_if.sv
// -----------------------------------------------------------------------------
// wb_req_guard_if
// Wishbone master-side bundle used by wb_req_guard.
//   master modport (the guard): drives cyc/stb/adr/we/dat_o/sel,
//                               receives dat_i/ack/err
//   slave modport  (the bus)  : the mirror image
// Parameters: AW address width, DW data width (byte select is DW/8 wide).
// -----------------------------------------------------------------------------
interface wb_req_guard_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int BEW = DW / 8;

  logic           wbm_cyc_o;
  logic           wbm_stb_o;
  logic [AW-1:0]  wbm_adr_o;
  logic           wbm_we_o;
  logic [DW-1:0]  wbm_dat_o;
  logic [BEW-1:0] wbm_sel_o;
  logic [DW-1:0]  wbm_dat_i;
  logic           wbm_ack_i;
  logic           wbm_err_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_adr_o, wbm_we_o, wbm_dat_o, wbm_sel_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_adr_o, wbm_we_o, wbm_dat_o, wbm_sel_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i
  );
endinterface

// File: rtl/wb_req_timer.sv
// -----------------------------------------------------------------------------
// wb_req_timer
// Bus-phase timeout counter. The count is cleared by 'clear', otherwise
// increments on every enabled cycle. 'expired' is combinational: it flags the
// cycle in which the running count equals 'limit' (limit 0 never expires).
// Because 'limit' is compared live, a change takes effect on the next compare.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : zero the count on the next edge (priority over enable)
//   enable    : count this cycle / qualify expiry
//   limit     : timeout limit in cycles
//   expired   : count == limit while enabled and limit != 0
// -----------------------------------------------------------------------------
module wb_req_timer
  import wb_req_guard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [TMR_W-1:0] limit,
  output logic             expired
);

  logic [TMR_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (limit != '0) && (count_q == limit);

endmodule

// File: rtl/wb_req_guard.sv
// -----------------------------------------------------------------------------
// wb_req_guard
// Turns a level-held register request (reg_cs) into exactly one Wishbone
// classic cycle, with error and timeout reporting.
//
// Ports:
//   app_clk, reset   : clock, synchronous active-high reset
//   cfg_timeout[16]  : bus-phase timeout in cycles, 0 disables
//   reg_cs/addr/wdata/wr/be : request side (held until reg_ack, then dropped)
//   reg_ack          : one-cycle completion pulse
//   reg_rdata        : read data (0 for writes, all-ones on err/timeout),
//                      held until the next reg_ack
//   reg_err, reg_timeout : completion status, only nonzero with reg_ack
//   wbm              : Wishbone master bundle (wb_req_guard_if.master)
//   err_cnt, last_err_addr : only when WB_REQ_GUARD_STATUS_EN is defined;
//                      saturating count of err/timeout completions and the
//                      address of the latest one
//
// Optional feature macro: WB_REQ_GUARD_STATUS_EN
// -----------------------------------------------------------------------------
module wb_req_guard
  import wb_req_guard_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic              app_clk,
  input  logic              reset,
  input  logic [15:0]       cfg_timeout,
  input  logic              reg_cs,
  input  logic [AW-1:0]     reg_addr,
  input  logic [DW-1:0]     reg_wdata,
  input  logic              reg_wr,
  input  logic [DW/8-1:0]   reg_be,
  output logic              reg_ack,
  output logic [DW-1:0]     reg_rdata,
  output logic              reg_err,
  output logic              reg_timeout,
`ifdef WB_REQ_GUARD_STATUS_EN
  output logic [7:0]        err_cnt,
  output logic [AW-1:0]     last_err_addr,
`endif
  wb_req_guard_if.master    wbm
);

  localparam int BEW = DW / 8;

  state_e         state_q, state_d;
  logic           cyc_q, cyc_d;
  logic [AW-1:0]  adr_q, adr_d;
  logic           we_q, we_d;
  logic [DW-1:0]  dat_q, dat_d;
  logic [BEW-1:0] sel_q, sel_d;
  logic           ack_q, ack_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           err_q, err_d;
  logic           tmo_q, tmo_d;

  logic           tmr_clear;
  logic           tmr_expired;

  wb_req_timer u_timer (
    .clk     (app_clk),
    .rst     (reset),
    .clear   (tmr_clear),
    .enable  (state_q == ST_BUS),
    .limit   (cfg_timeout),
    .expired (tmr_expired)
  );

  // Next-state and registered-output logic. Bus outputs are registered, so
  // cyc/stb rise on the edge that samples reg_cs and fall on the edge that
  // samples the completion.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    adr_d     = adr_q;
    we_d      = we_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    ack_d     = 1'b0;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    tmo_d     = 1'b0;
    tmr_clear = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (reg_cs) begin
          state_d   = ST_BUS;
          cyc_d     = 1'b1;
          adr_d     = reg_addr;
          we_d      = reg_wr;
          dat_d     = reg_wdata;
          sel_d     = reg_be;
          tmr_clear = 1'b1;
        end
      end

      ST_BUS: begin
        // err beats ack, and either beats a timeout in the same cycle
        if (wbm.wbm_err_i) begin
          state_d = ST_RELEASE;
          cyc_d   = 1'b0;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          rdata_d = ERR_DATA[DW-1:0];
        end else if (wbm.wbm_ack_i) begin
          state_d = ST_RELEASE;
          cyc_d   = 1'b0;
          ack_d   = 1'b1;
          rdata_d = we_q ? '0 : wbm.wbm_dat_i;
        end else if (tmr_expired) begin
          state_d = ST_RELEASE;
          cyc_d   = 1'b0;
          ack_d   = 1'b1;
          tmo_d   = 1'b1;
          rdata_d = ERR_DATA[DW-1:0];
        end
      end

      ST_RELEASE: begin
        // a still-held reg_cs belongs to the finished request
        if (!reg_cs) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge app_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cyc_q   <= 1'b0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      dat_q   <= '0;
      sel_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign wbm.wbm_cyc_o = cyc_q;
  assign wbm.wbm_stb_o = cyc_q;
  assign wbm.wbm_adr_o = adr_q;
  assign wbm.wbm_we_o  = we_q;
  assign wbm.wbm_dat_o = dat_q;
  assign wbm.wbm_sel_o = sel_q;

  assign reg_ack     = ack_q;
  assign reg_rdata   = rdata_q;
  assign reg_err     = err_q;
  assign reg_timeout = tmo_q;

`ifdef WB_REQ_GUARD_STATUS_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [AW-1:0] last_err_addr_q, last_err_addr_d;

  always_comb begin
    err_cnt_d       = err_cnt_q;
    last_err_addr_d = last_err_addr_q;
    if (ack_d && (err_d || tmo_d)) begin
      err_cnt_d       = sat_inc8(err_cnt_q);
      last_err_addr_d = adr_q;
    end
  end

  always_ff @(posedge app_clk) begin
    if (reset) begin
      err_cnt_q       <= '0;
      last_err_addr_q <= '0;
    end else begin
      err_cnt_q       <= err_cnt_d;
      last_err_addr_q <= last_err_addr_d;
    end
  end

  assign err_cnt       = err_cnt_q;
  assign last_err_addr = last_err_addr_q;
`endif

endmodule

// File: tb/tb_wb_req_guard.sv
// -----------------------------------------------------------------------------
// tb_wb_req_guard
// Scoreboarded bench for wb_req_guard. Each request's outcome is predicted
// from the response/timeout rules (response cycle vs. timeout cycle), pushed
// into a queue, and popped by an independent monitor on every reg_ack.
// -----------------------------------------------------------------------------
module tb_wb_req_guard;

  localparam int AW = 32;
  localparam int DW = 32;

  localparam int R_ACK    = 0;
  localparam int R_ERR    = 1;
  localparam int R_BOTH   = 2;
  localparam int R_SILENT = 3;

  logic          app_clk = 1'b0;
  logic          reset;
  logic [15:0]   cfg_timeout;
  logic          reg_cs;
  logic [31:0]   reg_addr;
  logic [31:0]   reg_wdata;
  logic          reg_wr;
  logic [3:0]    reg_be;
  logic          reg_ack;
  logic [31:0]   reg_rdata;
  logic          reg_err;
  logic          reg_timeout;
`ifdef WB_REQ_GUARD_STATUS_EN
  logic [7:0]    err_cnt;
  logic [31:0]   last_err_addr;
`endif

  wb_req_guard_if #(.AW(AW), .DW(DW)) wb ();

  wb_req_guard #(.AW(AW), .DW(DW)) dut (
    .app_clk       (app_clk),
    .reset         (reset),
    .cfg_timeout   (cfg_timeout),
    .reg_cs        (reg_cs),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_wr        (reg_wr),
    .reg_be        (reg_be),
    .reg_ack       (reg_ack),
    .reg_rdata     (reg_rdata),
    .reg_err       (reg_err),
    .reg_timeout   (reg_timeout),
`ifdef WB_REQ_GUARD_STATUS_EN
    .err_cnt       (err_cnt),
    .last_err_addr (last_err_addr),
`endif
    .wbm           (wb)
  );

  initial forever #5 app_clk = ~app_clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [3:0]  be;
    logic [15:0] tmo0;
    logic [15:0] tmo1;
    int          chg;
    int          waits;
    int          resp;
    logic [31:0] sdata;
    int          hold;
  } req_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    int          cyc_len;
    logic [7:0]  ecnt;
    logic [31:0] eaddr;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          cyc_starts = 0;
  int          plan_waits = 0;
  int          plan_resp = R_SILENT;
  logic [31:0] plan_sdata = 32'h0;
  int          stray_req = 0;
  int          m_ecnt = 0;
  logic [31:0] m_eaddr = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Outcome from the rules: the slave answers in bus cycle 'waits' (never if
  // silent); the timeout fires in the first bus cycle whose index equals the
  // limit in force then (tmo0 before cycle chg, tmo1 from chg on). A response
  // in the same cycle as the timeout wins; err wins over ack.
  function automatic exp_t model(input req_t r);
    exp_t e;
    int   resp_c;
    int   tmo_c;
    resp_c = (r.resp == R_SILENT) ? -1 : r.waits;
    tmo_c  = -1;
    if (r.tmo0 != 16'd0 && int'(r.tmo0) < r.chg) tmo_c = int'(r.tmo0);
    else if (r.tmo1 != 16'd0 && int'(r.tmo1) >= r.chg) tmo_c = int'(r.tmo1);
    e.addr  = r.addr;
    e.wdata = r.wdata;
    e.wr    = r.wr;
    e.be    = r.be;
    e.ecnt  = 8'h0;
    e.eaddr = 32'h0;
    if (resp_c >= 0 && (tmo_c < 0 || resp_c <= tmo_c)) begin
      e.err     = (r.resp == R_ERR || r.resp == R_BOTH);
      e.tmo     = 1'b0;
      e.rdata   = e.err ? 32'hFFFF_FFFF : (r.wr ? 32'h0 : r.sdata);
      e.cyc_len = resp_c + 1;
    end else begin
      e.err     = 1'b0;
      e.tmo     = 1'b1;
      e.rdata   = 32'hFFFF_FFFF;
      e.cyc_len = tmo_c + 1;
    end
    return e;
  endfunction

  // Slave: answers in bus cycle plan_waits; outside a bus cycle it can
  // inject a stray ack+err that the guard must ignore.
  initial begin
    int bus_c;
    int stray_done;
    bus_c = 0;
    stray_done = 0;
    wb.wbm_ack_i = 1'b0;
    wb.wbm_err_i = 1'b0;
    wb.wbm_dat_i = 32'h0;
    forever begin
      @(negedge app_clk);
      wb.wbm_ack_i = 1'b0;
      wb.wbm_err_i = 1'b0;
      wb.wbm_dat_i = $urandom;
      if (wb.wbm_cyc_o && wb.wbm_stb_o) begin
        bus_c++;
        if (bus_c == plan_waits + 1) begin
          case (plan_resp)
            R_ACK:  begin wb.wbm_ack_i = 1'b1; wb.wbm_dat_i = plan_sdata; end
            R_ERR:  wb.wbm_err_i = 1'b1;
            R_BOTH: begin wb.wbm_ack_i = 1'b1; wb.wbm_err_i = 1'b1; end
            default: ;
          endcase
        end
      end else begin
        bus_c = 0;
        if (stray_done != stray_req) begin
          wb.wbm_ack_i = 1'b1;
          wb.wbm_err_i = 1'b1;
          stray_done++;
        end
      end
    end
  end

  // Monitor: bus-side stability against the pending request, and reg-side
  // completions against the scoreboard.
  initial begin
    int   cyc_run;
    logic prev_cyc;
    exp_t e;
    cyc_run  = 0;
    prev_cyc = 1'b0;
    forever begin
      @(negedge app_clk);
      if (reset) begin
        cyc_run  = 0;
        prev_cyc = 1'b0;
      end else begin
        if (wb.wbm_cyc_o && !prev_cyc) cyc_starts++;
        if (wb.wbm_cyc_o) begin
          cyc_run++;
          chk("stb_eq_cyc", 64'(wb.wbm_stb_o), 64'(1'b1));
          if (q.size() == 0) begin
            chk("bus_without_request", 64'(1'b1), 64'(1'b0));
          end else begin
            chk("wbm_adr", 64'(wb.wbm_adr_o), 64'(q[0].addr));
            chk("wbm_we",  64'(wb.wbm_we_o),  64'(q[0].wr));
            chk("wbm_dat", 64'(wb.wbm_dat_o), 64'(q[0].wdata));
            chk("wbm_sel", 64'(wb.wbm_sel_o), 64'(q[0].be));
          end
        end
        if (reg_ack) begin
          done_cnt++;
          if (q.size() == 0) begin
            chk("unexpected_ack", 64'(1'b1), 64'(1'b0));
          end else begin
            e = q.pop_front();
            chk("reg_rdata",   64'(reg_rdata),   64'(e.rdata));
            chk("reg_err",     64'(reg_err),     64'(e.err));
            chk("reg_timeout", 64'(reg_timeout), 64'(e.tmo));
            chk("cyc_len",     64'(cyc_run),     64'(e.cyc_len));
`ifdef WB_REQ_GUARD_STATUS_EN
            chk("err_cnt",       64'(err_cnt),       64'(e.ecnt));
            chk("last_err_addr", 64'(last_err_addr), 64'(e.eaddr));
`endif
          end
          cyc_run = 0;
        end else begin
          chk("status_without_ack", 64'({reg_err, reg_timeout}), 64'(2'b00));
        end
        prev_cyc = wb.wbm_cyc_o;
      end
    end
  end

  // Caller is positioned #1 after a rising edge; returns likewise.
  task automatic run_txn(input req_t r);
    exp_t e;
    int   target;
    int   k;
    e = model(r);
    if (e.err || e.tmo) begin
      if (m_ecnt < 255) m_ecnt++;
      m_eaddr = r.addr;
    end
    e.ecnt  = 8'(m_ecnt);
    e.eaddr = m_eaddr;
    q.push_back(e);
    plan_waits  = r.waits;
    plan_resp   = r.resp;
    plan_sdata  = r.sdata;
    cfg_timeout = r.tmo0;
    reg_cs      = 1'b1;
    reg_addr    = r.addr;
    reg_wdata   = r.wdata;
    reg_wr      = r.wr;
    reg_be      = r.be;
    target = done_cnt + 1;
    k = 0;
    while (done_cnt < target && k < 200) begin
      @(posedge app_clk);
      #1;
      if (k == 0) begin
        // request fields are registered by now; scramble them
        reg_addr  = $urandom;
        reg_wdata = $urandom;
        reg_wr    = 1'($urandom);
        reg_be    = 4'($urandom);
      end
      if (k == r.chg) cfg_timeout = r.tmo1;
      k++;
    end
    if (done_cnt < target) begin
      chk("ack_wait_budget", 64'(1'b0), 64'(1'b1));
      q.delete();
    end
    if (r.hold > 0) begin
      stray_req++;
      repeat (r.hold) begin
        @(posedge app_clk);
        #1;
      end
    end
    reg_cs = 1'b0;
    @(posedge app_clk);
    #1;
  endtask

  function automatic req_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic wr, input int waits, input int resp,
                              input logic [15:0] tmo, input logic [31:0] sdata,
                              input int hold);
    req_t r;
    r.addr = addr; r.wdata = wdata; r.wr = wr; r.be = 4'hF;
    r.tmo0 = tmo; r.tmo1 = tmo; r.chg = 1;
    r.waits = waits; r.resp = resp; r.sdata = sdata; r.hold = hold;
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req_t r;
    int   base;
    int   starts0;

    reset = 1'b1; cfg_timeout = 16'd0; reg_cs = 1'b0;
    reg_addr = 32'h0; reg_wdata = 32'h0; reg_wr = 1'b0; reg_be = 4'h0;
    repeat (3) @(posedge app_clk);
    #1;
    chk("rst_cyc",     64'(wb.wbm_cyc_o), 64'(1'b0));
    chk("rst_stb",     64'(wb.wbm_stb_o), 64'(1'b0));
    chk("rst_we",      64'(wb.wbm_we_o),  64'(1'b0));
    chk("rst_adr",     64'(wb.wbm_adr_o), 64'(32'h0));
    chk("rst_dat",     64'(wb.wbm_dat_o), 64'(32'h0));
    chk("rst_sel",     64'(wb.wbm_sel_o), 64'(4'h0));
    chk("rst_ack",     64'(reg_ack),      64'(1'b0));
    chk("rst_rdata",   64'(reg_rdata),    64'(32'h0));
    chk("rst_err_tmo", 64'({reg_err, reg_timeout}), 64'(2'b00));
`ifdef WB_REQ_GUARD_STATUS_EN
    chk("rst_err_cnt", 64'(err_cnt), 64'(8'h0));
    chk("rst_last_err_addr", 64'(last_err_addr), 64'(32'h0));
`endif
    reset = 1'b0;
    @(posedge app_clk);
    #1;

    // Read with three wait states: four bus cycles
    run_txn(mk(32'h3000_0010, 32'h0, 1'b0, 3, R_ACK, 16'd0, 32'hA5A5_1234, 0));

    // Write: read data returns zero
    r = mk(32'h3000_0004, 32'h55, 1'b1, 1, R_ACK, 16'd0, 32'hDEAD_BEEF, 0);
    run_txn(r);

    // Silent slave, timeout 8, then a late ack/err while in RELEASE
    base = done_cnt;
    run_txn(mk(32'h3000_0008, 32'h0, 1'b0, 0, R_SILENT, 16'd8, 32'h0, 3));
    repeat (3) begin @(posedge app_clk); #1; end
    chk("late_ack_ignored", 64'(done_cnt), 64'(base + 1));

    // ack and err together resolve as error
    run_txn(mk(32'h3000_0020, 32'h0, 1'b0, 2, R_BOTH, 16'd0, 32'h1234_5678, 0));

    // Ack in the same cycle the timeout would fire: ack wins
    run_txn(mk(32'h3000_0030, 32'h0, 1'b0, 4, R_ACK, 16'd4, 32'h0BAD_F00D, 0));

    // Timeout limit lowered from 20 to 10 during the bus phase
    r = mk(32'h3000_0040, 32'h0, 1'b0, 0, R_SILENT, 16'd20, 32'h0, 0);
    r.tmo1 = 16'd10; r.chg = 5;
    run_txn(r);

    // Held reg_cs yields a single bus cycle; re-request yields another
    starts0 = cyc_starts;
    run_txn(mk(32'h3000_0050, 32'h0, 1'b0, 1, R_ACK, 16'd0, 32'hCAFE_0001, 20));
    chk("held_cs_one_cycle", 64'(cyc_starts), 64'(starts0 + 1));
    run_txn(mk(32'h3000_0054, 32'h0, 1'b0, 0, R_ACK, 16'd0, 32'hCAFE_0002, 0));
    chk("second_request_cycle", 64'(cyc_starts), 64'(starts0 + 2));

    // Reset during the bus phase: cyc drops, no reg_ack
    r = mk(32'h3000_0060, 32'h0, 1'b0, 0, R_SILENT, 16'd0, 32'h0, 0);
    q.push_back(model(r));
    plan_waits = 0; plan_resp = R_SILENT; cfg_timeout = 16'd0;
    reg_cs = 1'b1; reg_addr = r.addr; reg_wdata = r.wdata; reg_wr = 1'b0; reg_be = 4'hF;
    base = done_cnt;
    repeat (4) begin @(posedge app_clk); #1; end
    chk("bus_before_reset", 64'(wb.wbm_cyc_o), 64'(1'b1));
    reset = 1'b1;
    reg_cs = 1'b0;
    @(posedge app_clk);
    #1;
    chk("reset_mid_bus_cyc", 64'(wb.wbm_cyc_o), 64'(1'b0));
    chk("reset_mid_bus_ack", 64'(reg_ack),      64'(1'b0));
    q.delete();
    m_ecnt = 0;
    m_eaddr = 32'h0;
    reset = 1'b0;
    repeat (4) begin @(posedge app_clk); #1; end
    chk("after_reset_idle_cyc", 64'(wb.wbm_cyc_o), 64'(1'b0));
    chk("after_reset_no_ack",   64'(done_cnt),     64'(base));
    run_txn(mk(32'h3000_0070, 32'h0, 1'b0, 2, R_ACK, 16'd0, 32'h7777_0000, 0));

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      r.addr  = $urandom;
      r.wdata = $urandom;
      r.wr    = 1'($urandom);
      r.be    = 4'($urandom);
      r.waits = int'($urandom_range(0, 12));
      r.resp  = int'($urandom_range(0, 3));
      r.tmo0  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 15));
      if (r.resp == R_SILENT && r.tmo0 == 16'd0) r.tmo0 = 16'd6;
      r.tmo1  = r.tmo0;
      r.chg   = 1;
      r.sdata = $urandom;
      r.hold  = int'($urandom_range(0, 3));
      run_txn(r);
    end

`ifdef WB_REQ_GUARD_STATUS_EN
    // Drive the error counter into saturation
    for (int i = 0; i < 258; i++) begin
      run_txn(mk(32'h4000_0000 + 32'(i), 32'h0, 1'b0, 0, R_ERR, 16'd0, 32'h0, 0));
    end
`endif

    repeat (3) begin @(posedge app_clk); #1; end
    chk("scoreboard_drained", 64'(q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_req_guard.md
WB_REQ_GUARD -- requirements
Module: wb_req_guard

Interface
- REQ-001 SHALL have parameter AW, default 32, meaning the Wishbone/reg address width.
- REQ-002 SHALL have parameter DW, default 32, meaning the data width; BEW = DW/8 is derived and is not a parameter.
- REQ-003 SHALL have port app_clk, input, 1, the single clock; all logic is rising-edge.
- REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
- REQ-005 SHALL have port cfg_timeout, input, 16, the timeout limit in app_clk cycles; 0 disables the timeout.
- REQ-006 SHALL have reg-side inputs reg_cs (1, level request), reg_addr (AW), reg_wdata (DW), reg_wr (1, 1 = write) and reg_be (BEW).
- REQ-007 SHALL have reg-side outputs reg_ack (1, one-cycle pulse), reg_rdata (DW), reg_err (1) and reg_timeout (1); reg_err and reg_timeout are valid only with reg_ack.
- REQ-008 SHALL have Wishbone master outputs wbm_cyc_o, wbm_stb_o, wbm_adr_o[AW], wbm_we_o, wbm_dat_o[DW] and wbm_sel_o[BEW].
- REQ-009 SHALL have Wishbone master inputs wbm_dat_i[DW], wbm_ack_i and wbm_err_i.

Function
- REQ-010 SHALL implement an FSM with states IDLE, BUS and RELEASE.
- REQ-011 In IDLE with reg_cs=1, it SHALL register addr, wdata, wr and be, then enter BUS. wbm_cyc_o and wbm_stb_o rise on that same edge, one cycle after reg_cs is sampled.
- REQ-012 In BUS, wbm_cyc_o = wbm_stb_o = 1 and the address, data, we and sel outputs SHALL hold constant.
- REQ-013 On wbm_ack_i in BUS, the block SHALL do all of the following on the next edge, then enter RELEASE:
  - drop cyc/stb;
  - pulse reg_ack for 1 cycle;
  - set reg_rdata = wbm_dat_i for a read, or 0 for a write;
  - set reg_err = 0.
- REQ-014 On wbm_err_i in BUS, the block SHALL behave as REQ-013 except reg_err = 1 and reg_rdata = all-ones.
- REQ-015 In BUS, a 16-bit counter cleared on BUS entry SHALL increment each cycle. When count == cfg_timeout, cfg_timeout != 0 and there is no ack/err, the block SHALL abort: drop cyc/stb, pulse reg_ack with reg_timeout = 1 and reg_rdata = all-ones, then enter RELEASE.
- REQ-016 Simultaneous wbm_err_i and wbm_ack_i SHALL resolve as error. Ack or err arriving in the same cycle as the timeout condition SHALL take precedence over the timeout.
- REQ-017 In RELEASE, the block SHALL wait for reg_cs = 0, then return to IDLE. A held reg_cs SHALL never reissue a transaction.
- REQ-018 wbm_ack_i or wbm_err_i received outside BUS SHALL be ignored.
- REQ-019 reg_rdata SHALL hold its last value until the next reg_ack. reg_err and reg_timeout SHALL be 0 whenever reg_ack = 0.
- REQ-020 A change of cfg_timeout mid-transaction SHALL take effect on the next compare.

Reset
- REQ-021 reset SHALL force IDLE and set the counter, cyc, stb, we, adr, dat_o, sel, reg_ack, reg_rdata, reg_err and reg_timeout to 0.
- REQ-022 Reset asserted during BUS SHALL drop cyc/stb on the next edge with no reg_ack.

Configuration
- REQ-023 With WB_REQ_GUARD_STATUS_EN defined, the block SHALL add outputs err_cnt[7:0] and last_err_addr[AW].
  - err_cnt is a saturating count (at 255) of err and timeout completions.
  - last_err_addr holds the address of the latest one.
  - Both reset to 0.
- REQ-024 Without WB_REQ_GUARD_STATUS_EN, those ports and registers SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
- REQ-025 A shared package wb_req_guard_pkg SHALL hold the FSM state enum typedef and the all-ones error data constant.
- REQ-026 The timeout counter SHALL be a sub-module wb_req_timer (inputs clear, enable, limit; output expired).

Verification
- REQ-027 Read, addr 0x3000_0010, slave acks after 3 cycles with 0xA5A5_1234 -> one reg_ack; reg_rdata = 0xA5A5_1234; reg_err = 0; cyc high exactly 4 cycles.
- REQ-028 Write 0x55 to 0x3000_0004 with be = 0xF -> wbm_we_o = 1, wbm_sel_o = 0xF, wbm_dat_o = 0x55; reg_ack with reg_rdata = 0.
- REQ-029 cfg_timeout = 8, slave silent -> reg_ack with reg_timeout = 1 and reg_rdata = 0xFFFF_FFFF; a late ack 2 cycles later produces no further reg_ack.
- REQ-030 ack and err together -> reg_err = 1; with STATUS_EN, err_cnt increments and last_err_addr = the request address.
- REQ-031 reg_cs held high for 20 cycles after the ack -> exactly one Wishbone cycle; after reg_cs drops and rises again, a second cycle starts.
- REQ-032 reset asserted mid-BUS -> cyc = 0 on the next edge; no reg_ack; FSM returns to IDLE.
